two_to_one_stream_mux: RTL and testbench
========================================

Name: two_to_one_stream_mux

Overview:
- Merges two independent packet streams (channel 0, channel 1) onto one output stream with valid/ready handshakes.
- Inverse of the team's 1x2 demux. Each output beat carries a select tag (out_sel) that a downstream demux uses to route it back.
- Round-robin arbitration at packet granularity: once a channel wins, it holds the output until its last beat is accepted.
- One registered output stage gives 1-cycle latency and full throughput.

Parameters:
- WIDTH, 8, data width of each input and output beat.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  enable; when low, no new beats are accepted
- in0_data  input  WIDTH  channel 0 beat data
- in0_last  input  1  channel 0 last beat of packet
- in0_valid  input  1  channel 0 beat valid
- in0_ready  output  1  channel 0 beat accepted this cycle when high with in0_valid
- in1_data  input  WIDTH  channel 1 beat data
- in1_last  input  1  channel 1 last beat of packet
- in1_valid  input  1  channel 1 beat valid
- in1_ready  output  1  channel 1 beat accepted this cycle when high with in1_valid
- out_data  output  WIDTH  registered beat data
- out_sel  output  1  source channel of the current output beat (0/1)
- out_last  output  1  registered last flag
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high. All registers update on posedge clk only.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, state=IDLE, last_grant=1 (channel 0 preferred first).
- Output register handshake:
  - load_ok = !out_valid | out_ready.
  - A transfer on channel x occurs when inx_valid & inx_ready.
  - On transfer: out_data, out_last <= inx_data, inx_last; out_sel <= x; out_valid <= 1.
  - If out_valid & out_ready with no input transfer that cycle: out_valid <= 0; data/sel/last hold.
  - Output regs are stable while out_valid & !out_ready.
- Ready generation (combinational from state, valids, en, load_ok; never from out_valid alone): inx_ready = en & load_ok & grant_x.
- Readiness rules:
  - At most one of in0_ready/in1_ready is high in any cycle.
  - A valid input must not be required to wait for its own ready.
  - Ready may depend on valid.
- Latency: 1 cycle from accepted input beat to out_valid. Sustains 1 beat/cycle with out_ready held high.
- State machine (IDLE, HOLD0, HOLD1):
  - IDLE, grant:
    - Both valid: the channel != last_grant.
    - Only one valid: that channel.
    - Neither valid: no grant.
  - IDLE, on transfer from x:
    - If last: stay IDLE; last_grant <= x.
    - Else: go to HOLDx.
  - HOLDx: grant only x; the other channel's ready=0 even if valid. On transfer with inx_last=1: go to IDLE; last_grant <= x.
  - last_grant changes only at packet end.
- Boundary conditions:
  - en low: both readies 0; state and last_grant hold. The output register still drains via out_ready. Mid-packet HOLDx resumes when en returns.
  - Output stalled (out_valid & !out_ready): no transfer; state holds.
  - Single-beat packets (last=1 on first beat) alternate channels every beat when both are continuously valid.
  - inx_valid dropping mid-packet: state stays HOLDx; the other channel stays blocked.
  - rst asserted mid-packet or mid-stall: next cycle all regs at reset values, out_valid=0. The partial packet is discarded. A valid input beat presented in the rst cycle is not accepted (readies forced 0 while rst=1).

Decomposition:
- Shared package mux_pkg holds:
  - State typedef: IDLE=2'd0, HOLD0=2'd1, HOLD1=2'd2.
  - Constants SEL_CH0=1'b0, SEL_CH1=1'b1.
- One natural sub-module: rr_arbiter2.
  - Inputs: req[1:0], last_grant, lock, lock_ch.
  - Output: one-hot gnt[1:0], combinational.
  - Reused by later N:1 merge blocks.
- Top level owns the FSM, last_grant and the output register.

Test Plan:
- Reset: drive valids high with rst=1 for 2 cycles -> in0_ready=in1_ready=0, out_valid=0, out_data=0 after release edge.
- Single channel: in0 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3), out_ready=1 -> out_data A1,A2,A3 on 3 consecutive cycles, each 1 cycle after accept, out_sel=0, out_last only on A3.
- Round-robin: both valid with single-beat packets, in0=0x10.., in1=0x20.. -> output order 0x10,0x20,0x11,0x21 with out_sel 0,1,0,1.
- Packet lock: in0 starts 4-beat packet while in1 valid -> in1_ready=0 for all 4 beats; in1 beat appears on the cycle after in0 last is accepted.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0x55 -> out_data stays 0x55, both readies 0, no beat lost or duplicated when out_ready returns.
- Reset and en mid-packet: rst pulse during beat 2 of a 4-beat in1 packet -> out_valid=0, state IDLE, and the next grant with both valid goes to channel 0. en=0 for 2 cycles mid-packet -> no accepts, packet resumes on the same channel.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and constants for the stream merge blocks.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with packet lock; purely combinational, one-hot grant.
// While locked the grant stays on lock_ch whether or not it is currently requesting.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock,
    input  logic       lock_ch,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (lock) begin
            gnt = lock_ch ? 2'b10 : 2'b01;
        end else if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/two_to_one_stream_mux.sv
// Packet-granular round-robin 2:1 stream merge with a source tag on every output beat.
// Latency 1 cycle; input readies drop whenever the single output register cannot load.
module two_to_one_stream_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_sel_q, out_last_q, out_valid_q;

    logic             load_ok;
    logic [1:0]       gnt;
    logic             xfer0, xfer1, xfer;
    logic             xfer_ch, xfer_last;
    logic [WIDTH-1:0] xfer_data;

    assign load_ok = !out_valid_q || out_ready;

    rr_arbiter2 u_arb (
        .req        ({in1_valid, in0_valid}),
        .last_grant (last_grant_q),
        .lock       (state_q != IDLE),
        .lock_ch    (state_q == HOLD1),
        .gnt        (gnt)
    );

    // Readies are held low during reset so a beat presented alongside rst is never consumed.
    assign in0_ready = !rst && en && load_ok && gnt[0];
    assign in1_ready = !rst && en && load_ok && gnt[1];

    assign xfer0     = in0_valid && in0_ready;
    assign xfer1     = in1_valid && in1_ready;
    assign xfer      = xfer0 || xfer1;
    assign xfer_ch   = xfer1 ? SEL_CH1 : SEL_CH0;
    assign xfer_last = xfer1 ? in1_last : in0_last;
    assign xfer_data = xfer1 ? in1_data : in0_data;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            if (xfer_last) begin
                state_d      = IDLE;
                last_grant_d = xfer_ch;
            end else begin
                state_d = (xfer_ch == SEL_CH1) ? HOLD1 : HOLD0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_CH1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= SEL_CH0;
            out_last_q  <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= xfer_data;
            out_sel_q   <= xfer_ch;
            out_last_q  <= xfer_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_two_to_one_stream_mux.sv
// Directed scenarios followed by randomized traffic, checked against a queue-based reference model.
module tb_two_to_one_stream_mux;

    logic       clk = 1'b0;
    logic       rst, en, out_ready;
    logic [7:0] in0_data, in1_data, out_data;
    logic       in0_last, in0_valid, in0_ready;
    logic       in1_last, in1_valid, in1_ready;
    logic       out_sel, out_last, out_valid;

    two_to_one_stream_mux #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;
        logic       last;
        logic [7:0] data;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    owner    = -1;   // channel currently owning the output mid-packet, -1 when none
    int    last_ch  = 1;    // channel that finished the most recent packet
    bit    acc0, acc1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: samples just before the next posedge, advances one clock, returns at the negedge.
    task automatic cycle();
        logic  lok, ov, ordy, r, v0, v1;
        beat_t b0, b1;
        #4;
        ov   = out_valid;
        ordy = out_ready;
        lok  = !ov || ordy;
        r    = rst;
        v0   = in0_valid;
        v1   = in1_valid;
        b0   = {1'b0, in0_last, in0_data};
        b1   = {1'b1, in1_last, in1_data};
        chk("out_valid", ov, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_beat", {out_sel, out_last, out_data}, exp_q[0]);
        chk("one_ready", in0_ready & in1_ready, 0);
        if (r || !en || !lok) begin
            chk("ready_blocked", {in1_ready, in0_ready}, 2'b00);
        end else if (owner >= 0) begin
            chk("lock_other", (owner == 0) ? in1_ready : in0_ready, 0);
            if ((owner == 0) ? v0 : v1)
                chk("lock_own", (owner == 0) ? in0_ready : in1_ready, 1);
        end else if (v0 && v1) begin
            chk("rr_pick", {in1_ready, in0_ready}, (last_ch == 0) ? 2'b10 : 2'b01);
        end else if (v0) begin
            chk("only0", {in1_ready, in0_ready}, 2'b01);
        end else if (v1) begin
            chk("only1", {in1_ready, in0_ready}, 2'b10);
        end
        acc0 = v0 && in0_ready;
        acc1 = v1 && in1_ready;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            owner   = -1;
            last_ch = 1;
        end else begin
            if (ov && ordy) void'(exp_q.pop_front());
            if (acc0 || acc1) begin
                exp_q.push_back(acc1 ? b1 : b0);
                if ((acc1 ? b1.last : b0.last)) begin
                    owner   = -1;
                    last_ch = acc1 ? 1 : 0;
                end else begin
                    owner = acc1 ? 1 : 0;
                end
            end
        end
        @(negedge clk);
    endtask

    logic [7:0] exp_d [4];
    logic       exp_s [4];
    logic [6:0] d0, d1;

    initial begin
        rst = 1'b1; en = 1'b1; out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h00; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h00; in1_last = 1'b0;
        @(negedge clk);

        // reset with valids high
        cycle();
        cycle();
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data, 8'h00);
        chk("rst_sel",   out_sel, 0);
        chk("rst_last",  out_last, 0);

        // single channel 3-beat packet
        rst = 1'b0; in1_valid = 1'b0;
        in0_data = 8'hA1; in0_last = 1'b0;
        cycle();
        chk("t2_acc1", acc0, 1);
        chk("t2_d1", {out_valid, out_sel, out_last, out_data}, {3'b100, 8'hA1});
        in0_data = 8'hA2;
        cycle();
        chk("t2_d2", {out_valid, out_sel, out_last, out_data}, {3'b100, 8'hA2});
        in0_data = 8'hA3; in0_last = 1'b1;
        cycle();
        chk("t2_d3", {out_valid, out_sel, out_last, out_data}, {3'b101, 8'hA3});
        in0_valid = 1'b0;
        cycle();
        chk("t2_drain", out_valid, 0);

        // round robin of single-beat packets from a fresh reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        in0_valid = 1'b1; in0_data = 8'h10; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h20; in1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_data", out_data, exp_d[k]);
            chk("t3_sel",  out_sel, exp_s[k]);
            if (acc0) in0_data = in0_data + 8'd1;
            if (acc1) in1_data = in1_data + 8'd1;
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        cycle();

        // packet lock: 4-beat in0 packet while in1 waits
        in0_valid = 1'b1; in0_data = 8'h30; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h40; in1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t4_acc0", acc0, 1);
            chk("t4_blk1", acc1, 0);
            in0_data = in0_data + 8'd1;
            in0_last = (in0_data == 8'h33);
        end
        in0_valid = 1'b0;
        cycle();
        chk("t4_acc1", acc1, 1);
        chk("t4_out", {out_sel, out_data}, {1'b1, 8'h40});
        in1_valid = 1'b0;
        cycle();

        // backpressure
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b1;
        cycle();
        chk("t5_load", {out_valid, out_data}, {1'b1, 8'h55});
        in0_data = 8'h56;
        in1_valid = 1'b1; in1_data = 8'h66; in1_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_noacc", acc0 | acc1, 0);
            chk("t5_hold", {out_valid, out_data}, {1'b1, 8'h55});
        end
        out_ready = 1'b1;
        cycle();
        chk("t5_next", {out_sel, out_data}, {1'b1, 8'h66});
        in1_valid = 1'b0;
        cycle();
        chk("t5_after", {out_sel, out_data}, {1'b0, 8'h56});
        in0_valid = 1'b0;
        cycle();

        // reset mid in1 packet
        in1_valid = 1'b1; in1_data = 8'h70; in1_last = 1'b0;
        cycle();
        in1_data = 8'h71;
        in0_valid = 1'b1; in0_data = 8'h80; in0_last = 1'b1;
        rst = 1'b1;
        cycle();
        chk("t6_rst_acc", acc0 | acc1, 0);
        chk("t6_rst_out", out_valid, 0);
        rst = 1'b0;
        cycle();
        chk("t6_grant0", {acc1, acc0}, 2'b01);
        in0_valid = 1'b0; in1_valid = 1'b0;
        cycle();

        // en low mid-packet
        in0_valid = 1'b1; in0_data = 8'h90; in0_last = 1'b0;
        cycle();
        in0_data = 8'h91;
        in1_valid = 1'b1; in1_data = 8'hA0; in1_last = 1'b1;
        cycle();
        chk("t7_pre", {acc1, acc0}, 2'b01);
        in0_data = 8'h92;
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t7_en_off", acc0 | acc1, 0);
        end
        en = 1'b1;
        cycle();
        chk("t7_resume", {acc1, acc0}, 2'b01);
        in0_data = 8'h93; in0_last = 1'b1;
        cycle();
        chk("t7_end", {acc1, acc0}, 2'b01);
        in0_valid = 1'b0;
        cycle();
        chk("t7_in1", acc1, 1);
        in1_valid = 1'b0;
        cycle();

        // randomized traffic
        d0 = '0; d1 = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!in0_valid || acc0) begin
                if (acc0) d0 = d0 + 7'd1;
                in0_valid = ($urandom_range(3) != 0);
                in0_data  = {1'b0, d0};
                in0_last  = ($urandom_range(2) == 0);
            end
            if (!in1_valid || acc1) begin
                if (acc1) d1 = d1 + 7'd1;
                in1_valid = ($urandom_range(3) != 0);
                in1_data  = {1'b1, d1};
                in1_last  = ($urandom_range(2) == 0);
            end
            en        = ($urandom_range(9) != 0);
            out_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(199) == 0);
            cycle();
        end

        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        cycle();
        cycle();
        chk("final_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
